ad4003_sample_packer: RTL and testbench

//  Consumes parallel 18-bit two's-complement conversion results from the AD4003 deserializer, one frame per conversion.

---
 rtl/ad4003_sample_packer.sv | 100 ++++++++++
 tb/tb_ad4003_sample_packer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad4003_sample_packer.sv
// ad4003_sample_packer: tags AD4003 frames with channel/sequence, serialises them to 32-bit words through a FWFT FIFO.
// Optional AD4003_PACK_AVG_EN averages 2**AVG_LOG2 frames per emitted frame.
module ad4003_sample_packer #(
  parameter int N_CH = 2,
  parameter int FIFO_AW = 5,
  parameter int AVG_LOG2 = 2
) (
  input  logic                 adc_read_clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic [N_CH*18-1:0]   sample_data,
  input  logic                 clear_overrun,
  output logic [31:0]          m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 overrun,
  output logic [15:0]          overrun_count,
  output logic [FIFO_AW:0]     fifo_level
);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;
  logic [3:0] ch;
  logic [9:0] seq;
  logic [N_CH*18-1:0] frame, next_frame;
  logic [31:0] mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic push, pop, room, accept, drop;
  assign push = state == EMIT;
  assign pop = m_tvalid & m_tready;
  assign fifo_level = wr_ptr - rd_ptr;
  assign room = fifo_level <= (FIFO_AW+1)'(DEPTH - N_CH);
  assign m_tvalid = wr_ptr != rd_ptr;
  assign m_tdata = m_tvalid ? mem[rd_ptr[FIFO_AW-1:0]] : 32'd0;
  assign m_tlast = m_tvalid && m_tdata[31:28] == 4'(N_CH-1);
`ifdef AD4003_PACK_AVG_EN
  localparam int ACC_W = 18 + AVG_LOG2;
  logic [AVG_LOG2:0] cnt;
  logic complete;
  assign complete = sample_valid & enable & (cnt == (AVG_LOG2+1)'((1 << AVG_LOG2) - 1));
  assign accept = complete & (state == IDLE) & room;
  assign drop = complete & ~accept;
  always_ff @(posedge adc_read_clk)
    if (rst || !enable) cnt <= '0;
    else if (sample_valid) cnt <= complete ? '0 : cnt + 1'b1;
  for (genvar k = 0; k < N_CH; k++) begin : g_avg
    logic signed [ACC_W-1:0] acc, sum;
    assign sum = acc + ACC_W'(signed'(sample_data[18*k +: 18]));
    assign next_frame[18*k +: 18] = 18'(sum >>> AVG_LOG2);
    always_ff @(posedge adc_read_clk)
      if (rst || !enable) acc <= '0;
      else if (sample_valid) acc <= complete ? '0 : sum;
  end
`else
  assign accept = sample_valid & enable & (state == IDLE) & room;
  assign drop = sample_valid & enable & ~accept;
  assign next_frame = sample_data;
`endif
  always_ff @(posedge adc_read_clk)
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      seq <= '0;
      frame <= '0;
    end else if (accept) begin
      frame <= next_frame;
      ch <= '0;
      state <= EMIT;
    end else if (state == EMIT) begin
      ch <= ch + 4'd1;
      if (ch == 4'(N_CH-1)) begin
        state <= IDLE;
        seq <= seq + 10'd1;
      end
    end
  // a drop coinciding with a clear leaves exactly that one drop recorded
  always_ff @(posedge adc_read_clk)
    if (rst) begin
      overrun <= 1'b0;
      overrun_count <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      overrun_count <= clear_overrun ? 16'd1 : (&overrun_count ? overrun_count : overrun_count + 16'd1);
    end else if (clear_overrun) begin
      overrun <= 1'b0;
      overrun_count <= '0;
    end
  always_ff @(posedge adc_read_clk)
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {ch, seq, frame[18*ch +: 18]};
  always_ff @(posedge adc_read_clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: tb/tb_ad4003_sample_packer.sv
// tb_ad4003_sample_packer: queue-based model plus directed literal checks for ad4003_sample_packer.
module tb_ad4003_sample_packer;
  localparam int N = 2, AW = 5, DEPTH = 32;
  logic clk = 0, rst = 1, enable = 0, sample_valid = 0, clear_overrun = 0, m_tready = 0;
  logic [N*18-1:0] sample_data = '0;
  logic [31:0] m_tdata;
  logic m_tvalid, m_tlast, overrun;
  logic [15:0] overrun_count;
  logic [AW:0] fifo_level;
  always #5 clk = ~clk;
  ad4003_sample_packer #(.N_CH(N), .FIFO_AW(AW), .AVG_LOG2(2)) dut (
    .adc_read_clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .clear_overrun(clear_overrun), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .overrun(overrun),
    .overrun_count(overrun_count), .fifo_level(fifo_level));
  int tests = 0, fails = 0;
  logic [31:0] q[$], pend[$], log_q[$];
  int mseq, m_cnt;
  bit m_ovr;
`ifdef AD4003_PACK_AVG_EN
  int acc [N];
  int acnt;
`endif
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic logic [31:0] lg(input int i);
    return i < log_q.size() ? log_q[i] : 32'hxxxxxxxx;
  endfunction
  // model: a frame is taken only when no earlier frame still has words waiting to enter the FIFO
  always @(posedge clk) begin
    bit busy, cand, take, drop;
    int sz;
    logic [N*18-1:0] fr;
    if (rst) begin
      q.delete(); pend.delete(); log_q.delete();
      mseq = 0; m_ovr = 0; m_cnt = 0;
`ifdef AD4003_PACK_AVG_EN
      acnt = 0;
      for (int k = 0; k < N; k++) acc[k] = 0;
`endif
    end else begin
      busy = pend.size() != 0;
      sz = q.size();
      take = 0; drop = 0;
      fr = sample_data;
      if (m_tvalid && m_tready) log_q.push_back(m_tdata);
`ifdef AD4003_PACK_AVG_EN
      cand = 0;
      if (!enable) begin
        acnt = 0;
        for (int k = 0; k < N; k++) acc[k] = 0;
      end else if (sample_valid) begin
        for (int k = 0; k < N; k++) acc[k] += int'(signed'(sample_data[18*k +: 18]));
        acnt++;
        if (acnt == 4) begin
          for (int k = 0; k < N; k++) fr[18*k +: 18] = 18'((acc[k] - (((acc[k] % 4) + 4) % 4)) / 4);
          cand = 1;
          acnt = 0;
          for (int k = 0; k < N; k++) acc[k] = 0;
        end
      end
`else
      cand = sample_valid && enable;
`endif
      if (cand) begin
        if (!busy && DEPTH - sz >= N) take = 1;
        else drop = 1;
      end
      if (m_tready && sz != 0) void'(q.pop_front());
      if (busy) q.push_back(pend.pop_front());
      if (take) begin
        for (int k = 0; k < N; k++) pend.push_back({4'(k), 10'(mseq), fr[18*k +: 18]});
        mseq = (mseq + 1) % 1024;
      end
      if (drop) begin
        m_ovr = 1;
        m_cnt = clear_overrun ? 1 : (m_cnt < 65535 ? m_cnt + 1 : m_cnt);
      end else if (clear_overrun) begin
        m_ovr = 0;
        m_cnt = 0;
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    chk("tvalid", 32'(m_tvalid), 32'(q.size() != 0));
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("tdata", m_tdata, q.size() != 0 ? q[0] : 32'd0);
    chk("tlast", 32'(m_tlast), q.size() != 0 ? 32'(q[0][31:28] == 4'(N-1)) : 32'd0);
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("ovr_count", 32'(overrun_count), 32'(m_cnt));
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [17:0] a, input logic [17:0] b);
    sample_data = {b, a};
    sample_valid = 1;
    idle(1);
    sample_valid = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    idle(2);
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", 32'(m_tlast), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_count", 32'(overrun_count), 0);
    chk("rst_level", 32'(fifo_level), 0);
    rst = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && m_tvalid; i++) idle(1);
    chk("drain", 32'(m_tvalid), 0);
  endtask
  initial begin
    do_reset();
    enable = 1;
    m_tready = 1;
`ifndef AD4003_PACK_AVG_EN
    send(18'h00001, 18'h3FFFF);
    idle(1);
    chk("t1_latency", 32'(m_tvalid), 1);
    idle(4);
    chk("t1_w0", lg(0), 32'h00000001);
    chk("t1_w1", lg(1), 32'h1003FFFF);
    send(18'h00055, 18'h000AA);
    idle(5);
    chk("t1_seq1", 32'(lg(2)[27:18]), 1);
    enable = 0;
    send(18'h1, 18'h2);
    idle(4);
    chk("dis_ignored", 32'(log_q.size()), 4);
    enable = 1;
    send(18'h7, 18'h8);
    enable = 0;
    idle(5);
    chk("enable_fall", lg(5), 32'h10080008);
    enable = 1;
    do_reset();
    m_tready = 0;
    for (int i = 0; i < 17; i++) begin
      send(18'(i), 18'(i + 100));
      idle(2);
    end
    chk("t2_level", 32'(fifo_level), 32);
    chk("t2_overrun", 32'(overrun), 1);
    chk("t2_count", 32'(overrun_count), 1);
    m_tready = 1;
    drain();
    chk("t2_last", lg(31), {4'd1, 10'd15, 18'd115});
    log_q.delete();
    send(18'h3, 18'h4);
    idle(5);
    chk("t2_seq16", lg(0), {4'd0, 10'd16, 18'h3});
    do_reset();
    sample_data = {18'h00022, 18'h00011};
    sample_valid = 1;
    idle(1);
    sample_data = {18'h00044, 18'h00033};
    idle(1);
    sample_valid = 0;
    idle(4);
    chk("t3_count", 32'(overrun_count), 1);
    chk("t3_w0", lg(0), 32'h00000011);
    chk("t3_w1", lg(1), 32'h10000022);
    chk("t3_words", 32'(log_q.size()), 2);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      sample_valid = 1;
      idle(2);
      sample_valid = 0;
      idle(3);
    end
    chk("t5_pre", 32'(overrun_count), 2);
    sample_valid = 1;
    idle(1);
    clear_overrun = 1;
    idle(1);
    clear_overrun = 0;
    sample_valid = 0;
    chk("t5_overrun", 32'(overrun), 1);
    chk("t5_count", 32'(overrun_count), 1);
    idle(3);
    clear_overrun = 1;
    idle(1);
    clear_overrun = 0;
    chk("t5_clr_ovr", 32'(overrun), 0);
    chk("t5_clr_cnt", 32'(overrun_count), 0);
    sample_valid = 1;
    idle(1);
    rst = 1;
    sample_valid = 0;
    idle(1);
    rst = 0;
    chk("rst_mid", 32'(fifo_level), 0);
    do_reset();
    for (int i = 0; i < 1030; i++) begin
      send(18'(i), 18'(i));
      idle(2);
    end
    idle(4);
    chk("t4_words", 32'(log_q.size()), 2060);
    chk("t4_seq1023", 32'(lg(2046)[27:18]), 1023);
    chk("t4_seq_wrap", 32'(lg(2048)[27:18]), 0);
    chk("t4_w2049", lg(2049), {4'd1, 10'd0, 18'd1024});
`else
    send(18'd4, 18'd0); idle(2);
    send(18'd5, 18'd0); idle(2);
    send(18'd6, 18'd0); idle(2);
    send(18'h3FFFD, 18'd0);
    idle(5);
    chk("t6_words", 32'(log_q.size()), 2);
    chk("t6_avg3", lg(0), 32'h00000003);
    send(18'h3FFFF, 18'd8); idle(2);
    send(18'd0, 18'd8); idle(2);
    send(18'd0, 18'd8); idle(2);
    send(18'd0, 18'd8);
    idle(5);
    chk("t6_floor", lg(2), {4'd0, 10'd1, 18'h3FFFF});
    chk("t6_ch1", lg(3), {4'd1, 10'd1, 18'd8});
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
